// File: rtl/bp_be_fma_sched.sv
// Issue scheduler for the shared FMA pipe: arbitrates imul and fma-class ops
// and reserves writeback slots so the single result port never collides.
module bp_be_fma_sched #(
    parameter int imul_latency_p = 4,
    parameter int fma_latency_p  = 5
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic imul_v_i,
    output logic imul_ready_o,
    input  logic fma_v_i,
    output logic fma_ready_o,
    input  logic fence_i,
    input  logic flush_i,
    output logic issue_v_o,
    output logic issue_sel_o,
    output logic wb_v_o,
    output logic wb_sel_o,
    output logic idle_o
);

    localparam logic [3:0] ImulChk = 4'(imul_latency_p);
    localparam logic [3:0] FmaChk  = 4'(fma_latency_p);
    localparam logic [3:0] ImulSet = 4'(imul_latency_p - 1);
    localparam logic [3:0] FmaSet  = 4'(fma_latency_p - 1);

    logic [8:0] occ_r, tag_r;
    logic [8:0] occ_n, tag_n;
    logic       prio_r;

    logic can_grant;
    logic imul_elig, fma_elig;
    logic imul_gnt, fma_gnt;

    // Reset is folded in so no grant leaks out while reset_n_i is low.
    assign can_grant = reset_n_i & ~fence_i & ~flush_i;

    // Slot L is the one that lands on L-1 after this edge's shift.
    assign imul_elig = imul_v_i & can_grant & ~occ_r[ImulChk];
    assign fma_elig  = fma_v_i & can_grant & ~occ_r[FmaChk];

    assign imul_gnt = imul_elig & (~fma_elig | ~prio_r);
    assign fma_gnt  = fma_elig & (~imul_elig | prio_r);

    assign imul_ready_o = imul_gnt;
    assign fma_ready_o  = fma_gnt;
    assign issue_v_o    = imul_gnt | fma_gnt;
    assign issue_sel_o  = fma_gnt;

    assign wb_v_o   = occ_r[0] & ~flush_i;
    assign wb_sel_o = tag_r[0];
    assign idle_o   = ~|occ_r & ~issue_v_o;

    always_comb begin
        occ_n = {1'b0, occ_r[8:1]};
        tag_n = {1'b0, tag_r[8:1]};
        if (imul_gnt) begin
            occ_n[ImulSet] = 1'b1;
            tag_n[ImulSet] = 1'b0;
        end
        if (fma_gnt) begin
            occ_n[FmaSet] = 1'b1;
            tag_n[FmaSet] = 1'b1;
        end
        if (flush_i) begin
            occ_n = '0;
            tag_n = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            occ_r  <= '0;
            tag_r  <= '0;
            prio_r <= 1'b0;
        end else begin
            occ_r <= occ_n;
            tag_r <= tag_n;
            // Hand priority to the other side only when both were competing.
            if (issue_v_o && imul_v_i && fma_v_i)
                prio_r <= ~prio_r;
        end
    end

endmodule

// File: tb/tb_bp_be_fma_sched.sv
// Scoreboard bench for bp_be_fma_sched: a 4/5-latency instance for most
// scenarios and a 4/4 instance for round-robin alternation.
module tb_bp_be_fma_sched;

    localparam int IL = 4;
    localparam int FL = 5;
    localparam int RL = 4;

    typedef struct {
        int   cyc;
        logic sel;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n = 0;
    int   fails = 0;

    exp_t q[$];
    exp_t rq[$];

    logic imul_v, fma_v, fence, flush;
    logic imul_rdy, fma_rdy, iss_v, iss_sel, wb_v, wb_sel, idle;

    logic r_imul_v, r_fma_v, r_fence, r_flush;
    logic r_imul_rdy, r_fma_rdy, r_iss_v, r_iss_sel, r_wb_v, r_wb_sel, r_idle;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bp_be_fma_sched #(.imul_latency_p(IL), .fma_latency_p(FL)) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .imul_v_i(imul_v), .imul_ready_o(imul_rdy),
        .fma_v_i(fma_v), .fma_ready_o(fma_rdy),
        .fence_i(fence), .flush_i(flush),
        .issue_v_o(iss_v), .issue_sel_o(iss_sel),
        .wb_v_o(wb_v), .wb_sel_o(wb_sel), .idle_o(idle)
    );

    bp_be_fma_sched #(.imul_latency_p(RL), .fma_latency_p(RL)) dut_rr (
        .clk_i(clk), .reset_n_i(rst_n),
        .imul_v_i(r_imul_v), .imul_ready_o(r_imul_rdy),
        .fma_v_i(r_fma_v), .fma_ready_o(r_fma_rdy),
        .fence_i(r_fence), .flush_i(r_flush),
        .issue_v_o(r_iss_v), .issue_sel_o(r_iss_sel),
        .wb_v_o(r_wb_v), .wb_sel_o(r_wb_sel), .idle_o(r_idle)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // Writeback monitors: pop the expected slot whenever a result appears.
    always @(negedge clk) begin
        if (rst_n) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                n++;
                fails++;
                $display("FAIL wb_missing want_cyc=%0d got=none", q[0].cyc);
                void'(q.pop_front());
            end
            if (wb_v) begin
                n++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL wb_unexpected cyc=%0d got sel=%0b want=none",
                             cyc, wb_sel);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (e.cyc != cyc || e.sel !== wb_sel) begin
                        fails++;
                        $display("FAIL wb got cyc=%0d sel=%0b want cyc=%0d sel=%0b",
                                 cyc, wb_sel, e.cyc, e.sel);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            while (rq.size() > 0 && rq[0].cyc < cyc) begin
                n++;
                fails++;
                $display("FAIL rr_wb_missing want_cyc=%0d got=none", rq[0].cyc);
                void'(rq.pop_front());
            end
            if (r_wb_v) begin
                n++;
                if (rq.size() == 0) begin
                    fails++;
                    $display("FAIL rr_wb_unexpected cyc=%0d got sel=%0b want=none",
                             cyc, r_wb_sel);
                end else begin
                    exp_t e;
                    e = rq.pop_front();
                    if (e.cyc != cyc || e.sel !== r_wb_sel) begin
                        fails++;
                        $display("FAIL rr_wb got cyc=%0d sel=%0b want cyc=%0d sel=%0b",
                                 cyc, r_wb_sel, e.cyc, e.sel);
                    end
                end
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic i, logic f, logic fe, logic fl);
        imul_v = i;
        fma_v  = f;
        fence  = fe;
        flush  = fl;
        #1;
    endtask

    task automatic eg(logic ei, logic ef);
        chk("imul_ready", imul_rdy, ei);
        chk("fma_ready", fma_rdy, ef);
        chk("issue_v", iss_v, ei | ef);
        if (ei | ef) chk("issue_sel", iss_sel, ef);
        if (ei) q.push_back('{cyc + IL, 1'b0});
        if (ef) q.push_back('{cyc + FL, 1'b1});
    endtask

    task automatic idle_cycles(int k);
        for (int i = 0; i < k; i++) begin
            next();
            drive(0, 0, 0, 0);
            eg(0, 0);
        end
    endtask

    initial begin
        imul_v = 1'b1; fma_v = 1'b1; fence = 1'b0; flush = 1'b0;
        r_imul_v = 1'b0; r_fma_v = 1'b0; r_fence = 1'b0; r_flush = 1'b0;

        // Reset state with requests pending
        #12;
        chk("rst_imul_ready", imul_rdy, 0);
        chk("rst_fma_ready", fma_rdy, 0);
        chk("rst_issue_v", iss_v, 0);
        chk("rst_wb_v", wb_v, 0);
        chk("rst_idle", idle, 1);

        // First cycle after release may grant; latency check on fma
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 1, 0, 0);
        eg(0, 1);
        chk("lat_idle_c0", idle, 0);
        for (int k = 1; k <= 5; k++) begin
            next();
            drive(0, 0, 0, 0);
            eg(0, 0);
            if (k == 5) begin
                chk("lat_wb_c5", wb_v, 1);
                chk("lat_idle_c5", idle, 0);
            end
        end
        next();
        drive(0, 0, 0, 0);
        chk("lat_idle_c6", idle, 1);

        // Slot collision: imul blocked one cycle behind an fma
        next(); drive(0, 1, 0, 0); eg(0, 1);
        next(); drive(1, 0, 0, 0); eg(0, 0);
        next(); drive(1, 0, 0, 0); eg(1, 0);
        idle_cycles(7);
        chk("coll_idle", idle, 1);

        // Priority toggling when both request
        next(); drive(1, 1, 0, 0); eg(1, 0);
        next(); drive(1, 1, 0, 0); eg(0, 1);
        next(); drive(1, 1, 0, 0); eg(0, 1);
        idle_cycles(8);

        // Fence blocks grants but in-flight op drains
        next(); drive(0, 1, 0, 0); eg(0, 1);
        for (int k = 1; k <= 3; k++) begin
            next();
            drive(0, 1, 1, 0);
            eg(0, 0);
        end
        next(); drive(0, 1, 0, 0); eg(0, 1);
        next(); drive(0, 0, 0, 0); eg(0, 0);
        chk("fence_wb_v", wb_v, 1);
        chk("fence_wb_sel", wb_sel, 1);
        idle_cycles(6);

        // Flush with three in flight, fence raised alongside
        next(); drive(1, 0, 0, 0); eg(1, 0);
        next(); drive(0, 1, 0, 0); eg(0, 1);
        next(); drive(0, 1, 0, 0); eg(0, 1);
        next(); drive(0, 0, 0, 0); eg(0, 0);
        next();
        q.delete();
        drive(1, 1, 1, 1);
        eg(0, 0);
        chk("flush_wb_mask", wb_v, 0);
        next(); drive(0, 0, 0, 0); eg(0, 0);
        chk("flush_idle", idle, 1);
        chk("flush_wb_after", wb_v, 0);
        idle_cycles(5);

        // Asynchronous reset mid-cycle with ops in flight
        next(); drive(0, 1, 0, 0); eg(0, 1);
        next(); drive(0, 1, 0, 0); eg(0, 1);
        #1;
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("arst_fma_ready", fma_rdy, 0);
        chk("arst_issue_v", iss_v, 0);
        chk("arst_wb_v", wb_v, 0);
        chk("arst_idle", idle, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 1, 0, 0);
        eg(0, 1);
        idle_cycles(8);
        chk("arst_final_idle", idle, 1);

        // Round robin on equal latencies
        for (int k = 0; k < 8; k++) begin
            next();
            r_imul_v = 1'b1;
            r_fma_v  = 1'b1;
            #1;
            chk("rr_imul_ready", r_imul_rdy, (k % 2) == 0);
            chk("rr_fma_ready", r_fma_rdy, (k % 2) == 1);
            rq.push_back('{cyc + RL, logic'(k % 2)});
        end
        next();
        r_imul_v = 1'b0;
        r_fma_v  = 1'b0;
        for (int k = 0; k < 6; k++) next();
        chk("rr_idle", r_idle, 1);

        chk("q_drained", q.size(), 0);
        chk("rq_drained", rq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n, fails);
        $finish;
    end

endmodule
